// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// Package : npu_pkg
// Purpose : Shared NPU definitions: vector geometry, reduction type codes,
//           pad constants, fill-state encoding and the per-type identity
//           element used to pad short vectors.
// Ports   : none (package).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package npu_pkg;

  localparam int NPU_VEC_LANES = 16;
  localparam int NPU_ELEM_W    = 16;

  localparam logic [2:0] RED_SUM  = 3'd0;
  localparam logic [2:0] RED_MAX  = 3'd1;
  localparam logic [2:0] RED_MIN  = 3'd2;
  localparam logic [2:0] RED_MEAN = 3'd3;

  localparam logic [NPU_ELEM_W-1:0] PAD_ZERO = 16'h0000;
  localparam logic [NPU_ELEM_W-1:0] PAD_MIN  = 16'hFFFF;

  typedef enum logic [0:0] {
    FILL_IDLE   = 1'b0,
    FILL_ACTIVE = 1'b1
  } fill_state_t;

  // Identity element of a reduction: padding with it leaves the result of
  // the reduction unchanged. Unknown codes fall back to zero.
  function automatic logic [NPU_ELEM_W-1:0] red_identity(input logic [2:0] red_type);
    logic [NPU_ELEM_W-1:0] id;
    case (red_type)
      RED_MIN:                    id = PAD_MIN;
      RED_SUM, RED_MAX, RED_MEAN: id = PAD_ZERO;
      default:                    id = PAD_ZERO;
    endcase
    return id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/packer_slot.sv
// ---------------------------------------------------------------------------
// Module  : packer_slot
// Purpose : One 16-lane vector slot. Writes one beat of IN_LANES elements at
//           the beat index, latches the type tag on the first beat, and on
//           the closing beat records the real-lane count and overwrites every
//           lane beyond it with the pad value.
// Macro   : NPU_PACKER_IDENTITY_PAD_EN - pad with the type's identity element
//           (otherwise pad with zero).
// Ports   : clk, rst_n (async, active-low)
//           i_wr     beat write enable for this slot
//           i_first  beat is the first of its vector (latch type)
//           i_close  beat completes the vector (set count, pad tail)
//           i_bc     beat index within the vector
//           i_data   beat payload, lane k at [16k+15:16k]
//           i_type   reduction type of the incoming vector
//           o_data / o_count / o_type  stored vector contents
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module packer_slot
  import npu_pkg::*;
#(
  parameter int IN_LANES = 4,
  parameter int BC_W     = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_wr,
  input  logic                              i_first,
  input  logic                              i_close,
  input  logic [BC_W-1:0]                   i_bc,
  input  logic [IN_LANES*NPU_ELEM_W-1:0]    i_data,
  input  logic [2:0]                        i_type,
  output logic [NPU_VEC_LANES*NPU_ELEM_W-1:0] o_data,
  output logic [4:0]                        o_count,
  output logic [2:0]                        o_type
);

  logic [2:0]            r_type;
  logic [4:0]            r_count;
  logic [4:0]            w_count;
  logic [NPU_ELEM_W-1:0] w_pad;

  assign w_count = 5'((int'(i_bc) + 1) * IN_LANES);

`ifdef NPU_PACKER_IDENTITY_PAD_EN
  // A single-beat vector closes on its first beat, before r_type is loaded.
  logic [2:0] w_type_eff;
  assign w_type_eff = i_first ? i_type : r_type;
  assign w_pad      = red_identity(w_type_eff);
`else
  assign w_pad      = PAD_ZERO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type  <= 3'd0;
      r_count <= 5'd0;
    end else if (i_wr) begin
      if (i_first) r_type  <= i_type;
      if (i_close) r_count <= w_count;
    end
  end

  assign o_type  = r_type;
  assign o_count = r_count;

  for (genvar i = 0; i < NPU_VEC_LANES; i++) begin : g_lane
    localparam int              LB   = i / IN_LANES;
    localparam int              LK   = i % IN_LANES;
    localparam logic [BC_W-1:0] C_LB = BC_W'(LB);

    logic [NPU_ELEM_W-1:0] r_lane;

    if (LB == 0) begin : g_head
      // Lanes of the first beat are always written; never padded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_lane <= '0;
        else if (i_wr && i_bc == C_LB)  r_lane <= i_data[LK*NPU_ELEM_W +: NPU_ELEM_W];
      end
    end else begin : g_tail
      // Lanes of beats not yet reached when the vector closes get the pad.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane <= '0;
        end else if (i_wr) begin
          if (i_bc == C_LB)                r_lane <= i_data[LK*NPU_ELEM_W +: NPU_ELEM_W];
          else if (i_close && i_bc < C_LB) r_lane <= w_pad;
        end
      end
    end

    assign o_data[i*NPU_ELEM_W +: NPU_ELEM_W] = r_lane;
  end

endmodule

`default_nettype wire

// File: rtl/reduction_lane_packer.sv
// ---------------------------------------------------------------------------
// Module  : reduction_lane_packer
// Purpose : Assembles a narrow stream of IN_LANES 16-bit elements per beat
//           into 16-lane vectors tagged with reduction type and real-lane
//           count. Two slots let one vector fill while the other drains.
// Macro   : NPU_PACKER_IDENTITY_PAD_EN - pad short vectors with the identity
//           element of their reduction type (otherwise zero).
// Ports   : clk, rst_n (async, active-low)
//           in_data/in_valid/in_ready/in_last/in_type  element beat input
//           vec_data/vec_valid/vec_ready/vec_count/vec_type  vector output
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module reduction_lane_packer
  import npu_pkg::*;
#(
  parameter int IN_LANES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [IN_LANES*NPU_ELEM_W-1:0]       in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [2:0]                           in_type,
  output logic [NPU_VEC_LANES*NPU_ELEM_W-1:0]  vec_data,
  output logic                                 vec_valid,
  input  logic                                 vec_ready,
  output logic [4:0]                           vec_count,
  output logic [2:0]                           vec_type
);

  localparam int              BEATS     = NPU_VEC_LANES / IN_LANES;
  localparam int              BC_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] C_LAST_BC = BC_W'(BEATS - 1);

  fill_state_t     r_state, w_state_nxt;
  logic [BC_W-1:0] r_bc, w_bc_nxt;
  logic            r_wp, r_rp;
  logic [1:0]      r_occ;

  logic w_accept, w_complete, w_drain, w_first;

  // Ready depends only on registered occupancy: no bypass from vec_ready.
  assign in_ready   = (r_occ != 2'd2);
  assign vec_valid  = (r_occ != 2'd0);
  assign w_accept   = in_valid && in_ready;
  assign w_first    = (r_state == FILL_IDLE);
  assign w_complete = w_accept && (in_last || r_bc == C_LAST_BC);
  assign w_drain    = vec_valid && vec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL_IDLE;
      r_bc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bc    <= w_bc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bc_nxt    = r_bc;
    if (w_accept) begin
      if (w_complete) begin
        w_state_nxt = FILL_IDLE;
        w_bc_nxt    = '0;
      end else begin
        w_state_nxt = FILL_ACTIVE;
        w_bc_nxt    = r_bc + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_complete) r_wp <= ~r_wp;
      if (w_drain)    r_rp <= ~r_rp;
      case ({w_complete, w_drain})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  logic [NPU_VEC_LANES*NPU_ELEM_W-1:0] w_slot_data  [2];
  logic [4:0]                          w_slot_count [2];
  logic [2:0]                          w_slot_type  [2];

  for (genvar s = 0; s < 2; s++) begin : g_slot
    packer_slot #(
      .IN_LANES (IN_LANES),
      .BC_W     (BC_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_accept && (r_wp == 1'(s))),
      .i_first (w_first),
      .i_close (w_complete),
      .i_bc    (r_bc),
      .i_data  (in_data),
      .i_type  (in_type),
      .o_data  (w_slot_data[s]),
      .o_count (w_slot_count[s]),
      .o_type  (w_slot_type[s])
    );
  end

  assign vec_data  = r_rp ? w_slot_data[1]  : w_slot_data[0];
  assign vec_count = r_rp ? w_slot_count[1] : w_slot_count[0];
  assign vec_type  = r_rp ? w_slot_type[1]  : w_slot_type[0];

endmodule

`default_nettype wire
